sb_hex_writer: RTL and testbench

System-bus initiator that pushes a 32-bit value onto the eight-digit hex display controller.

- Accepts a value plus digit-enable mask over a valid/ready handshake.
- Issues nine back-to-back single-cycle writes: HEX0..HEX7 (one nibble each), then BITM.
- Also issues the controller's soft-clear write on request.
- Sits between a producer (counter, debug probe, core-side shim) and the system-bus port of the hex controller, so the display works without software.

---
 rtl/sb_hex_pkg.sv | 37 +++
 rtl/sb_hex_writer.sv | 165 ++++++++++++++++
 tb/tb_sb_hex_writer.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/sb_hex_pkg.sv
// Register map, FSM states and word helpers for the eight-digit hex display writer.
// The hex display controller imports the same offset constants.
package sb_hex_pkg;

  localparam int HEX_DIGITS = 8;

  localparam logic [31:0] HEX0_OFF = 32'h00;
  localparam logic [31:0] HEX1_OFF = 32'h04;
  localparam logic [31:0] HEX2_OFF = 32'h08;
  localparam logic [31:0] HEX3_OFF = 32'h0C;
  localparam logic [31:0] HEX4_OFF = 32'h10;
  localparam logic [31:0] HEX5_OFF = 32'h14;
  localparam logic [31:0] HEX6_OFF = 32'h18;
  localparam logic [31:0] HEX7_OFF = 32'h1C;
  localparam logic [31:0] BITM_OFF = 32'h20;
  localparam logic [31:0] RST_OFF  = 32'h24;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_VERIFY,
    ST_CLEAR,
    ST_DONE
  } state_e;

  // Indices 0..7 select HEXn; index 8 lands on BITM right after HEX7.
  function automatic logic [31:0] reg_off(input logic [3:0] idx);
    return HEX0_OFF + {26'b0, idx, 2'b00};
  endfunction

  function automatic logic [31:0] reg_word(input logic [3:0] idx, input logic [31:0] val,
                                           input logic [7:0] mask);
    if (idx < 4'(HEX_DIGITS)) return {28'b0, val[{idx[2:0], 2'b00} +: 4]};
    else                      return {24'b0, mask};
  endfunction

endpackage

// File: rtl/sb_hex_writer.sv
// System-bus initiator that writes a 32-bit value and digit mask to the hex display controller.
// Define SB_HEX_WRITER_VERIFY_EN to build in the readback pass and err_o.
module sb_hex_writer
  import sb_hex_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] value_i,
  input  logic [7:0]  mask_i,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic        clear_i,
  output logic        done_o,
  output logic        err_o,
  output logic        req_o,
  output logic        write_enable_o,
  output logic [31:0] addr_o,
  output logic [31:0] write_data_o,
  input  logic [31:0] read_data_i
);

  localparam logic [3:0] LAST_IDX = 4'(HEX_DIGITS);

  state_e      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [31:0] val_q, val_d;
  logic [7:0]  mask_q, mask_d;
  logic        req_q, req_d, we_q, we_d, done_q, done_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
  logic        vtail_q, vtail_d;
  logic        accept;

  assign accept = (state_q == ST_IDLE) && !clear_i && valid_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      val_q   <= '0;
      mask_q  <= '0;
      vtail_q <= 1'b0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      val_q   <= val_d;
      mask_q  <= mask_d;
      vtail_q <= vtail_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    val_d   = val_q;
    mask_d  = mask_q;
    vtail_d = vtail_q;
    unique case (state_q)
      ST_IDLE: begin
        if (clear_i) state_d = ST_CLEAR;
        else if (valid_i) begin
          state_d = ST_WRITE;
          idx_d   = '0;
          val_d   = value_i;
          mask_d  = mask_i;
        end
      end
      ST_WRITE: begin
        if (idx_q == LAST_IDX) begin
          idx_d = '0;
`ifdef SB_HEX_WRITER_VERIFY_EN
          state_d = ST_VERIFY;
          vtail_d = 1'b0;
`else
          state_d = ST_DONE;
`endif
        end else idx_d = idx_q + 4'd1;
      end
`ifdef SB_HEX_WRITER_VERIFY_EN
      // One tail cycle after the last read so its data can be compared.
      ST_VERIFY: begin
        if (vtail_q)                 state_d = ST_DONE;
        else if (idx_q == LAST_IDX)  vtail_d = 1'b1;
        else                         idx_d   = idx_q + 4'd1;
      end
`endif
      ST_CLEAR: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Bus outputs are decoded from the next state so the registered copy lines up with it.
  always_comb begin
    req_d   = 1'b0;
    we_d    = 1'b0;
    addr_d  = '0;
    wdata_d = '0;
    done_d  = (state_d == ST_DONE);
    case (state_d)
      ST_WRITE: begin
        req_d   = 1'b1;
        we_d    = 1'b1;
        addr_d  = BASE_ADDR + reg_off(idx_d);
        wdata_d = reg_word(idx_d, val_d, mask_d);
      end
`ifdef SB_HEX_WRITER_VERIFY_EN
      ST_VERIFY: begin
        req_d  = !vtail_d;
        addr_d = vtail_d ? '0 : BASE_ADDR + reg_off(idx_d);
      end
`endif
      ST_CLEAR: begin
        req_d   = 1'b1;
        we_d    = 1'b1;
        addr_d  = BASE_ADDR + RST_OFF;
        wdata_d = 32'd1;
      end
      default: ;
    endcase
  end

`ifdef SB_HEX_WRITER_VERIFY_EN
  logic        chk_q, err_q;
  logic [31:0] exp_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      chk_q <= 1'b0;
      exp_q <= '0;
      err_q <= 1'b0;
    end else begin
      chk_q <= (state_q == ST_VERIFY) && !vtail_q;
      exp_q <= reg_word(idx_q, val_q, mask_q);
      if (accept)                                err_q <= 1'b0;
      else if (chk_q && (read_data_i != exp_q))  err_q <= 1'b1;
    end
  end

  assign err_o = err_q;
`else
  logic unused_rd;
  assign unused_rd = ^{read_data_i, accept};
  assign err_o     = 1'b0;
`endif

  assign ready_o        = (state_q == ST_IDLE);
  assign done_o         = done_q;
  assign req_o          = req_q;
  assign write_enable_o = we_q;
  assign addr_o         = addr_q;
  assign write_data_o   = wdata_q;

endmodule

// File: tb/tb_sb_hex_writer.sv
// Directed bench for sb_hex_writer: table of values with hand-computed bus words, plus
// clear, back-to-back, reset-abort and (verify build) readback corner sequences.
module tb_sb_hex_writer;

`ifdef SB_HEX_WRITER_VERIFY_EN
  localparam bit VERIFY = 1'b1;
`else
  localparam bit VERIFY = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_i, valid_i, clear_i;
  logic [31:0] value_i;
  logic [7:0]  mask_i;
  logic        ready_o, done_o, err_o, req_o, we_o;
  logic [31:0] addr_o, wdata_o;
  logic        ready1, done1, err1, req1, we1;
  logic [31:0] addr1, wdata1;
  logic [31:0] rdata = 32'h0;

  always #5 clk = ~clk;

  sb_hex_writer dut (
    .clk_i(clk), .rst_i(rst_i), .value_i(value_i), .mask_i(mask_i), .valid_i(valid_i),
    .ready_o(ready_o), .clear_i(clear_i), .done_o(done_o), .err_o(err_o), .req_o(req_o),
    .write_enable_o(we_o), .addr_o(addr_o), .write_data_o(wdata_o), .read_data_i(rdata)
  );

  sb_hex_writer #(.BASE_ADDR(32'h0700_0000)) dut_b (
    .clk_i(clk), .rst_i(rst_i), .value_i(value_i), .mask_i(mask_i), .valid_i(valid_i),
    .ready_o(ready1), .clear_i(clear_i), .done_o(done1), .err_o(err1), .req_o(req1),
    .write_enable_o(we1), .addr_o(addr1), .write_data_o(wdata1), .read_data_i(rdata)
  );

  // Register-file stand-in for the hex controller; read data one cycle after the request.
  logic        corrupt = 1'b0;
  logic [31:0] mem [16];
  always @(posedge clk) begin
    if (req_o && we_o) mem[addr_o[5:2]] <= wdata_o;
    if (req_o && !we_o) rdata <= (corrupt && addr_o[5:2] == 4'd3) ? 32'h0 : mem[addr_o[5:2]];
  end

  typedef struct packed {
    logic [31:0]      value;
    logic [7:0]       mask;
    logic [8:0][31:0] words;  // words[k] = expected data for write k
  } vec_t;

  vec_t vecs [4];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b want %b", nm, act, exp);
    end
  endtask

  // Caller is in the accept cycle N; returns in the cycle after done_o.
  task automatic run_op(input int v, input bit hold, input int nv, input logic exp_err);
    value_i = vecs[v].value;
    mask_i  = vecs[v].mask;
    valid_i = 1'b1;
    chk1("accept_ready", ready_o, 1'b1);
    step();
    if (hold) begin
      value_i = vecs[nv].value;
      mask_i  = vecs[nv].mask;
    end else valid_i = 1'b0;
    for (int k = 0; k < 9; k++) begin
      chk1($sformatf("v%0d_wr%0d_req", v, k), req_o, 1'b1);
      chk1($sformatf("v%0d_wr%0d_we", v, k), we_o, 1'b1);
      chk1($sformatf("v%0d_wr%0d_rdy", v, k), ready_o, 1'b0);
      chk($sformatf("v%0d_wr%0d_addr", v, k), addr_o, 32'(4 * k));
      chk($sformatf("v%0d_wr%0d_data", v, k), wdata_o, vecs[v].words[k]);
      chk($sformatf("v%0d_wr%0d_addr_b", v, k), addr1, 32'h0700_0000 + 32'(4 * k));
      step();
    end
    if (VERIFY) begin
      for (int k = 0; k < 9; k++) begin
        chk1($sformatf("v%0d_rd%0d_req", v, k), req_o, 1'b1);
        chk1($sformatf("v%0d_rd%0d_we", v, k), we_o, 1'b0);
        chk($sformatf("v%0d_rd%0d_addr", v, k), addr_o, 32'(4 * k));
        step();
      end
      chk1("verify_tail_req", req_o, 1'b0);
      chk1("verify_tail_done", done_o, 1'b0);
      step();
    end
    chk1($sformatf("v%0d_done", v), done_o, 1'b1);
    chk1($sformatf("v%0d_done_req", v), req_o, 1'b0);
    chk1($sformatf("v%0d_err", v), err_o, exp_err);
    step();
    chk1($sformatf("v%0d_ready_after", v), ready_o, 1'b1);
    chk1($sformatf("v%0d_done_drop", v), done_o, 1'b0);
  endtask

  initial begin
    vecs[0].value = 32'h1234_ABCD; vecs[0].mask = 8'hFF;
    vecs[0].words = {32'hFF, 32'h1, 32'h2, 32'h3, 32'h4, 32'hA, 32'hB, 32'hC, 32'hD};
    vecs[1].value = 32'hDEAD_BEEF; vecs[1].mask = 8'h0F;
    vecs[1].words = {32'h0F, 32'hD, 32'hE, 32'hA, 32'hD, 32'hB, 32'hE, 32'hE, 32'hF};
    vecs[2].value = 32'h0000_0000; vecs[2].mask = 8'h00;
    vecs[2].words = {32'h00, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    vecs[3].value = 32'hFFFF_FFFF; vecs[3].mask = 8'hA5;
    vecs[3].words = {32'hA5, 32'hF, 32'hF, 32'hF, 32'hF, 32'hF, 32'hF, 32'hF, 32'hF};

    rst_i = 1'b1; valid_i = 1'b0; clear_i = 1'b0; value_i = '0; mask_i = '0;
    step();
    step();
    rst_i = 1'b0;
    chk1("rst_req", req_o, 1'b0);
    chk1("rst_we", we_o, 1'b0);
    chk("rst_addr", addr_o, 32'h0);
    chk("rst_wdata", wdata_o, 32'h0);
    chk1("rst_done", done_o, 1'b0);
    chk1("rst_err", err_o, 1'b0);
    chk1("rst_ready", ready_o, 1'b1);

    // valid_i held: second value must wait for the first to finish and not leak into it.
    run_op(0, 1'b1, 3, 1'b0);
    run_op(3, 1'b0, 0, 1'b0);
    run_op(1, 1'b0, 0, 1'b0);
    corrupt = 1'b1;
    run_op(1, 1'b0, 0, VERIFY);
    corrupt = 1'b0;

    // clear_i beats valid_i; err_o survives the clear.
    clear_i = 1'b1; valid_i = 1'b1; value_i = 32'h5555_5555; mask_i = 8'h55;
    chk1("clr_ready_n", ready_o, 1'b1);
    step();
    clear_i = 1'b0; valid_i = 1'b0;
    chk1("clr_req", req_o, 1'b1);
    chk1("clr_we", we_o, 1'b1);
    chk("clr_addr", addr_o, 32'h24);
    chk("clr_data", wdata_o, 32'd1);
    chk("clr_addr_b", addr1, 32'h0700_0024);
    step();
    chk1("clr_done", done_o, 1'b1);
    chk1("clr_done_req", req_o, 1'b0);
    chk1("clr_err_kept", err_o, VERIFY);
    step();
    chk1("clr_ready", ready_o, 1'b1);
    chk1("clr_no_accept_req", req_o, 1'b0);
    chk1("clr_done_drop", done_o, 1'b0);

    run_op(2, 1'b0, 0, 1'b0);

    // Reset during the fourth write aborts cleanly.
    value_i = vecs[0].value; mask_i = vecs[0].mask; valid_i = 1'b1;
    step();
    valid_i = 1'b0;
    step();
    step();
    step();
    chk("abort_wr3_addr", addr_o, 32'h0C);
    chk("abort_wr3_data", wdata_o, 32'hA);
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    chk1("abort_req", req_o, 1'b0);
    chk1("abort_ready", ready_o, 1'b1);
    chk1("abort_done", done_o, 1'b0);
    for (int c = 0; c < 12; c++) begin
      step();
      chk1($sformatf("abort_idle%0d_req", c), req_o, 1'b0);
      chk1($sformatf("abort_idle%0d_done", c), done_o, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
